dac_mkid_4x_tx: RTL and testbench

Transmit-side counterpart of the MKID 4x ADC capture path. It accepts 4-way demultiplexed I/Q sample words from the DSP fabric with a valid/ready handshake and buffers them in a small FIFO. It serialises each word into one I/Q sample pair per clock for the DAC data pins, carrying frame sync and flagging underflow. The block sits between the tone-generation logic and the DAC pad/ODDR layer, all in the DAC clock domain.

---
 rtl/dac_mkid_pkg.sv | 25 ++
 rtl/dac_word_fifo.sv | 66 ++++++
 rtl/dac_mkid_4x_tx.sv | 175 +++++++++++++++++
 tb/tb_dac_mkid_4x_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_mkid_pkg.sv
// rtl/dac_mkid_pkg.sv - shared types and helpers for the MKID 4x DAC transmit path
package dac_mkid_pkg;

    localparam int SAMPLE_WIDTH = 12;

    // One demultiplexed word: four I and four Q samples, index 0 transmitted first.
    typedef struct packed {
        logic                             sync;
        logic [3:0][SAMPLE_WIDTH-1:0]     i;
        logic [3:0][SAMPLE_WIDTH-1:0]     q;
    } dac_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_t;

    // Code the DAC sees as zero amplitude. In offset-binary mode this is also the
    // mask that converts a two's complement sample (flip the MSB only).
    function automatic logic [SAMPLE_WIDTH-1:0] midscale(input logic offset_binary);
        return {offset_binary, {(SAMPLE_WIDTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/dac_word_fifo.sv
// rtl/dac_word_fifo.sv - synchronous word FIFO with occupancy count
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready  write side; ready depends on count only
//   m_tdata/m_tvalid/m_tready  read side; m_tdata shows the head entry
//   count                      current occupancy, 0..DEPTH
module dac_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // A pop in the same cycle does not free a slot for the push; this keeps
    // ready off the read-side timing path.
    assign s_tready = (count < CNT_W'(DEPTH));
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tready & m_tvalid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_mkid_4x_tx.sv
// rtl/dac_mkid_4x_tx.sv - 4x I/Q word buffer and serialiser for the MKID DAC
// Ports:
//   dac_clk, dac_rst_n               clock, asynchronous active-low reset
//   user_data_i0..3, user_data_q0..3 four-way I/Q word, index 0 sent first
//   user_sync, user_valid, user_ready word handshake; sync marks frame sample 0
//   enable                           streaming enable
//   dac_data_i, dac_data_q           registered samples, one pair per clock
//   dac_sync, dac_valid              frame sync on sample 0, real-sample flag
//   underflow, underflow_clr         sticky starvation flag and its clear
//   fifo_level                       buffered word count
module dac_mkid_4x_tx
    import dac_mkid_pkg::*;
#(
    parameter int DATA_WIDTH    = SAMPLE_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter int PRIME_LEVEL   = 2,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                          dac_clk,
    input  logic                          dac_rst_n,
    input  logic [DATA_WIDTH-1:0]         user_data_i0,
    input  logic [DATA_WIDTH-1:0]         user_data_i1,
    input  logic [DATA_WIDTH-1:0]         user_data_i2,
    input  logic [DATA_WIDTH-1:0]         user_data_i3,
    input  logic [DATA_WIDTH-1:0]         user_data_q0,
    input  logic [DATA_WIDTH-1:0]         user_data_q1,
    input  logic [DATA_WIDTH-1:0]         user_data_q2,
    input  logic [DATA_WIDTH-1:0]         user_data_q3,
    input  logic                          user_sync,
    input  logic                          user_valid,
    output logic                          user_ready,
    input  logic                          enable,
    output logic [DATA_WIDTH-1:0]         dac_data_i,
    output logic [DATA_WIDTH-1:0]         dac_data_q,
    output logic                          dac_sync,
    output logic                          dac_valid,
    output logic                          underflow,
    input  logic                          underflow_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                    LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic                  OB    = (OFFSET_BINARY != 0);
    // Midscale doubles as the output transform mask: XOR flips the MSB only
    // in offset-binary mode and is a pass-through otherwise.
    localparam logic [DATA_WIDTH-1:0] MID   = midscale(OB);

    dac_word_t in_word;
    dac_word_t head_word;
    dac_word_t hold;
    logic      fifo_nonempty;
    logic      pop;

    tx_state_t state;
    tx_state_t state_nxt;
    logic [1:0] phase;
    logic [1:0] phase_nxt;
    logic       underflow_set;
    logic       underflow_pend;

    assign in_word = {user_sync,
                      user_data_i3, user_data_i2, user_data_i1, user_data_i0,
                      user_data_q3, user_data_q2, user_data_q1, user_data_q0};

    dac_word_fifo #(
        .WIDTH ($bits(dac_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (dac_clk),
        .rst_n    (dac_rst_n),
        .s_tdata  (in_word),
        .s_tvalid (user_valid),
        .s_tready (user_ready),
        .m_tdata  (head_word),
        .m_tvalid (fifo_nonempty),
        .m_tready (pop),
        .count    (fifo_level)
    );

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        pop           = 1'b0;
        underflow_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
                    pop       = 1'b1;
                    state_nxt = ST_RUN;
                    phase_nxt = 2'd0;
                end
            end
            ST_RUN: begin
                if (phase != 2'd3) begin
                    phase_nxt = phase + 2'd1;
                end else if (!enable) begin
                    // Word finished; leave the buffered words in place.
                    state_nxt = ST_IDLE;
                    phase_nxt = 2'd0;
                end else if (fifo_nonempty) begin
                    pop       = 1'b1;
                    phase_nxt = 2'd0;
                end else begin
                    underflow_set = 1'b1;
                    state_nxt     = ST_PRIME;
                    phase_nxt     = 2'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            state <= ST_IDLE;
            phase <= 2'd0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            if (pop) begin
                hold <= head_word;
            end
        end
    end

    // Output register: samples come from the hold register in RUN, so the word
    // popped on the PRIME->RUN edge appears on the following edge.
    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            dac_data_i <= MID;
            dac_data_q <= MID;
            dac_sync   <= 1'b0;
            dac_valid  <= 1'b0;
        end else if (state == ST_RUN) begin
            dac_data_i <= hold.i[phase] ^ MID;
            dac_data_q <= hold.q[phase] ^ MID;
            dac_sync   <= hold.sync & (phase == 2'd0);
            dac_valid  <= 1'b1;
        end else begin
            dac_data_i <= MID;
            dac_data_q <= MID;
            dac_sync   <= 1'b0;
            dac_valid  <= 1'b0;
        end
    end

    // The flag is staged one cycle so it rises together with the first
    // midscale output after the starved word, not alongside its last sample.
    // A clear on either cycle wins over the set.
    always_ff @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            underflow_pend <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            underflow_pend <= underflow_set & ~underflow_clr;
            if (underflow_clr) begin
                underflow <= 1'b0;
            end else if (underflow_pend) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_mkid_4x_tx.sv
// tb/tb_dac_mkid_4x_tx.sv - randomized and directed bench for dac_mkid_4x_tx
module tb_dac_mkid_4x_tx;

    localparam int          DW    = 12;
    localparam int          DEPTH = 4;
    localparam int          PL    = 2;
    localparam logic [11:0] MID   = 12'h800;

    logic            dac_clk;
    logic            dac_rst_n;
    logic [3:0][11:0] drv_i;
    logic [3:0][11:0] drv_q;
    logic            user_sync;
    logic            user_valid;
    logic            user_ready;
    logic            enable;
    logic [11:0]     dac_data_i;
    logic [11:0]     dac_data_q;
    logic            dac_sync;
    logic            dac_valid;
    logic            underflow;
    logic            underflow_clr;
    logic [2:0]      fifo_level;

    dac_mkid_4x_tx #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .PRIME_LEVEL   (PL),
        .OFFSET_BINARY (1)
    ) dut (
        .dac_clk       (dac_clk),
        .dac_rst_n     (dac_rst_n),
        .user_data_i0  (drv_i[0]),
        .user_data_i1  (drv_i[1]),
        .user_data_i2  (drv_i[2]),
        .user_data_i3  (drv_i[3]),
        .user_data_q0  (drv_q[0]),
        .user_data_q1  (drv_q[1]),
        .user_data_q2  (drv_q[2]),
        .user_data_q3  (drv_q[3]),
        .user_sync     (user_sync),
        .user_valid    (user_valid),
        .user_ready    (user_ready),
        .enable        (enable),
        .dac_data_i    (dac_data_i),
        .dac_data_q    (dac_data_q),
        .dac_sync      (dac_sync),
        .dac_valid     (dac_valid),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .fifo_level    (fifo_level)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a queue of buffered words, the word being sent and the
    // index of the next sample, plus a mode (0 stopped, 1 waiting for data,
    // 2 streaming).
    typedef struct packed {
        logic             sync;
        logic [3:0][11:0] i;
        logic [3:0][11:0] q;
    } mw_t;

    mw_t         mq[$];
    mw_t         cur;
    mw_t         m_w;
    int          mode;
    int          idx;
    logic        m_starved;
    logic        m_uf_event;
    logic [11:0] exp_i;
    logic [11:0] exp_q;
    logic        exp_sync;
    logic        exp_valid;
    logic        exp_uf;
    int          exp_level;

    always @(posedge dac_clk or negedge dac_rst_n) begin
        if (!dac_rst_n) begin
            mq.delete();
            mode       = 0;
            idx        = 0;
            m_uf_event = 1'b0;
            exp_i      = MID;
            exp_q      = MID;
            exp_sync   = 1'b0;
            exp_valid  = 1'b0;
            exp_uf     = 1'b0;
            exp_level  = 0;
        end else begin
            if (mode == 2) begin
                exp_i     = cur.i[idx] ^ MID;
                exp_q     = cur.q[idx] ^ MID;
                exp_sync  = cur.sync && (idx == 0);
                exp_valid = 1'b1;
            end else begin
                exp_i     = MID;
                exp_q     = MID;
                exp_sync  = 1'b0;
                exp_valid = 1'b0;
            end
            m_w.sync  = user_sync;
            m_w.i     = drv_i;
            m_w.q     = drv_q;
            m_starved = 1'b0;
            case (mode)
                0: if (enable) mode = 1;
                1: begin
                    if (!enable) begin
                        mode = 0;
                    end else if (mq.size() >= PL) begin
                        cur  = mq.pop_front();
                        idx  = 0;
                        mode = 2;
                    end
                end
                default: begin
                    if (idx < 3) begin
                        idx++;
                    end else if (!enable) begin
                        mode = 0;
                    end else if (mq.size() > 0) begin
                        cur = mq.pop_front();
                        idx = 0;
                    end else begin
                        m_starved = 1'b1;
                        mode      = 1;
                    end
                end
            endcase
            // Acceptance is judged on the occupancy before this edge's pop.
            if (user_valid && (exp_level < DEPTH)) begin
                mq.push_back(m_w);
            end
            // Flag visible one cycle after starvation; a clear always wins.
            exp_uf     = underflow_clr ? 1'b0 : (exp_uf | m_uf_event);
            m_uf_event = m_starved && !underflow_clr;
            exp_level  = mq.size();
        end
    end

    logic [11:0] log_i[$];
    logic [11:0] log_q[$];
    logic        log_s[$];
    int          run_len = 0;
    int          max_run = 0;

    always @(negedge dac_clk) begin
        if (dac_rst_n) begin
            check("cycle {i,q,sync,valid,uf,ready,level}",
                  {1'b0, dac_data_i, dac_data_q, dac_sync, dac_valid, underflow, user_ready, fifo_level},
                  {1'b0, exp_i, exp_q, exp_sync, exp_valid, exp_uf, (exp_level < DEPTH), 3'(exp_level)});
            if (dac_valid) begin
                log_i.push_back(dac_data_i);
                log_q.push_back(dac_data_q);
                log_s.push_back(dac_sync);
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
    end

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge dac_clk);
    endtask

    task automatic push_word(input logic [3:0][11:0] wi, input logic [3:0][11:0] wq, input logic s);
        drv_i      = wi;
        drv_q      = wq;
        user_sync  = s;
        user_valid = 1'b1;
        @(negedge dac_clk);
        user_valid = 1'b0;
        user_sync  = 1'b0;
    endtask

    task automatic push_random(input int n);
        logic [3:0][11:0] ri;
        logic [3:0][11:0] rq;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                ri[j] = 12'($urandom);
                rq[j] = 12'($urandom);
            end
            push_word(ri, rq, 1'($urandom));
        end
    endtask

    task automatic pulse_clr();
        underflow_clr = 1'b1;
        @(negedge dac_clk);
        underflow_clr = 1'b0;
    endtask

    int sync_cnt;
    int waited;

    initial begin
        dac_rst_n     = 1'b0;
        enable        = 1'b1;
        user_valid    = 1'b0;
        user_sync     = 1'b0;
        underflow_clr = 1'b0;
        drv_i         = '0;
        drv_q         = '0;
        idle_cycles(3);
        dac_rst_n = 1'b1;
        idle_cycles(4);

        // Reset state with enable high and no data.
        check("reset dac_data_i", dac_data_i, 12'h800);
        check("reset dac_data_q", dac_data_q, 12'h800);
        check("reset dac_valid", dac_valid, 0);
        check("reset user_ready", user_ready, 1);
        check("reset underflow", underflow, 0);
        check("reset fifo_level", fifo_level, 0);

        // Two known words, offset-binary output.
        log_i.delete(); log_q.delete(); log_s.delete();
        push_word({12'd4, 12'd3, 12'd2, 12'd1}, {12'hFFC, 12'hFFD, 12'hFFE, 12'hFFF}, 1'b1);
        push_word({12'd8, 12'd7, 12'd6, 12'd5}, {12'hFF8, 12'hFF9, 12'hFFA, 12'hFFB}, 1'b0);
        idle_cycles(16);
        check("known words sample count", log_i.size(), 8);
        if (log_i.size() >= 8) begin
            check("i sample0", log_i[0], 12'h801);
            check("i sample1", log_i[1], 12'h802);
            check("i sample2", log_i[2], 12'h803);
            check("i sample3", log_i[3], 12'h804);
            check("i sample4", log_i[4], 12'h805);
            check("q sample0", log_q[0], 12'h7FF);
            check("q sample4", log_q[4], 12'h7FB);
            check("sync on first sample", log_s[0], 1);
            sync_cnt = 0;
            for (int k = 0; k < 8; k++) sync_cnt += int'(log_s[k]);
            check("sync count", sync_cnt, 1);
        end
        check("underflow after two words", underflow, 1);
        check("midscale after underflow", dac_data_i, 12'h800);
        pulse_clr();
        check("underflow cleared", underflow, 0);

        // Fill while disabled; the fifth word is refused.
        enable = 1'b0;
        idle_cycles(4);
        push_random(5);
        check("full user_ready", user_ready, 0);
        check("full fifo_level", fifo_level, 4);
        max_run = 0;
        enable  = 1'b1;
        idle_cycles(25);
        check("full buffer run length", max_run, 16);

        // Three words, starve, then resume with two more.
        pulse_clr();
        push_random(3);
        idle_cycles(20);
        check("starved underflow", underflow, 1);
        check("starved dac_valid", dac_valid, 0);
        push_random(2);
        idle_cycles(6);
        check("resumed dac_valid", dac_valid, 1);
        check("underflow held through recovery", underflow, 1);
        pulse_clr();
        check("underflow cleared while running", underflow, 0);

        // Drop enable while the first word's second sample is next.
        idle_cycles(12);
        pulse_clr();
        enable = 1'b0;
        idle_cycles(4);
        push_random(4);
        max_run = 0;
        enable  = 1'b1;
        waited  = 0;
        while (!(mode == 2 && idx == 1) && waited < 50) begin
            @(negedge dac_clk);
            waited++;
        end
        check("reached phase 1 within bound", waited < 50, 1);
        enable = 1'b0;
        idle_cycles(10);
        check("word completed after enable drop", max_run, 4);
        check("idle midscale after drop", dac_data_i, 12'h800);
        check("idle dac_valid after drop", dac_valid, 0);
        check("fifo retained after drop", fifo_level, 3);

        // Randomized traffic checked every cycle against the model.
        enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            user_valid = ($urandom_range(0, 2) != 0);
            user_sync  = 1'($urandom);
            for (int j = 0; j < 4; j++) begin
                drv_i[j] = 12'($urandom);
                drv_q[j] = 12'($urandom);
            end
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            underflow_clr = ($urandom_range(0, 49) == 0);
            @(negedge dac_clk);
        end
        user_valid    = 1'b0;
        underflow_clr = 1'b0;
        enable        = 1'b1;

        // Asynchronous reset in mid-stream.
        idle_cycles(20);
        push_random(3);
        idle_cycles(4);
        check("streaming before reset", dac_valid, 1);
        @(posedge dac_clk);
        #2 dac_rst_n = 1'b0;
        #1;
        check("async reset dac_data_i", dac_data_i, 12'h800);
        check("async reset dac_data_q", dac_data_q, 12'h800);
        check("async reset dac_valid", dac_valid, 0);
        check("async reset dac_sync", dac_sync, 0);
        check("async reset fifo_level", fifo_level, 0);
        check("async reset user_ready", user_ready, 1);
        check("async reset underflow", underflow, 0);
        @(negedge dac_clk);
        dac_rst_n = 1'b1;
        idle_cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
